// File: rtl/cp0_pkg.sv
// cp0_pkg: CP0 register numbers, field positions and exception codes
package cp0_pkg;
  localparam logic [4:0] CP0_COUNT = 5'd9;
  localparam logic [4:0] CP0_COMPARE = 5'd11;
  localparam logic [4:0] CP0_STATUS = 5'd12;
  localparam logic [4:0] CP0_CAUSE = 5'd13;
  localparam logic [4:0] CP0_EPC = 5'd14;
  localparam int IE_BIT = 0;
  localparam int EXL_BIT = 1;
  localparam int IM_LSB = 8;
  localparam int IP_LSB = 8;
  localparam int TI_BIT = 15;
  typedef enum logic [4:0] {
    EXC_INT = 5'd0,
    EXC_SYS = 5'd8,
    EXC_RI = 5'd10,
    EXC_OV = 5'd12
  } exc_code_t;
endpackage

// File: rtl/cp0_irq_latch.sv
// cp0_irq_latch: rising-edge detect per irq line into a W1C pending register
module cp0_irq_latch #(
  parameter int NUM_IRQ = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_IRQ-1:0] irq_in,
  input  logic [NUM_IRQ-1:0] clr,
  output logic [NUM_IRQ-1:0] pend
);
  logic [NUM_IRQ-1:0] prev;
  always_ff @(posedge clk) begin
    if (reset) begin
      prev <= '0;
      pend <= '0;
    end else begin
      prev <= irq_in;
      pend <= (pend & ~clr) | (irq_in & ~prev);
    end
  end
endmodule

// File: rtl/cp0_intc.sv
// cp0_intc: CP0 Status/Cause/EPC/Count/Compare with interrupt and exception arbitration
module cp0_intc
  import cp0_pkg::*;
#(
  parameter int NUM_IRQ = 4,
  parameter int XLEN = 32,
  parameter logic [XLEN-1:0] EXC_VECTOR = 32'h80000180
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [XLEN-1:0]    pc,
  input  logic               instr_done,
  input  logic [NUM_IRQ-1:0] irq_in,
  input  logic               exc_req,
  input  logic [4:0]         exc_code,
  input  logic               eret,
  input  logic               mtc0_en,
  input  logic [4:0]         addr,
  input  logic [XLEN-1:0]    wr_data,
  output logic [XLEN-1:0]    rd_data,
  output logic               take_exc,
  output logic [XLEN-1:0]    vector,
  output logic [XLEN-1:0]    epc,
  output logic [XLEN-1:0]    status,
  output logic [XLEN-1:0]    cause,
  output logic               int_pending
);
  logic ie, exl, ti, armed;
  logic [7:0] im, ip;
  logic [4:0] code;
  logic [XLEN-1:0] count, compare, epc_q;
  logic [NUM_IRQ-1:0] ext;
  logic wr_count, wr_compare, wr_status, wr_cause, wr_epc;
  assign wr_count = mtc0_en && addr == CP0_COUNT;
  assign wr_compare = mtc0_en && addr == CP0_COMPARE;
  assign wr_status = mtc0_en && addr == CP0_STATUS;
  assign wr_cause = mtc0_en && addr == CP0_CAUSE;
  assign wr_epc = mtc0_en && addr == CP0_EPC;
  cp0_irq_latch #(.NUM_IRQ(NUM_IRQ)) u_irq (
    .clk(clk),
    .reset(reset),
    .irq_in(irq_in),
    .clr(wr_cause ? wr_data[IP_LSB +: NUM_IRQ] : '0),
    .pend(ext)
  );
  assign ip = 8'(ext) | {ti, 7'b0};
  assign int_pending = ie & ~exl & |(ip & im);
  assign take_exc = ~reset & (exc_req | (instr_done & int_pending));
  assign status = XLEN'({im, 6'b0, exl, ie});
  assign cause = XLEN'({ip, 1'b0, code, 2'b0});
  assign epc = epc_q;
  assign vector = EXC_VECTOR;
  always_comb begin
    rd_data = addr == CP0_COUNT ? count :
              addr == CP0_COMPARE ? compare :
              addr == CP0_STATUS ? status :
              addr == CP0_CAUSE ? cause :
              addr == CP0_EPC ? epc_q : '0;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      ie <= 1'b0;
      exl <= 1'b0;
      ti <= 1'b0;
      armed <= 1'b0;
      im <= '0;
      code <= '0;
      count <= '0;
      compare <= '0;
      epc_q <= '0;
    end else begin
      count <= wr_count ? wr_data : count + XLEN'(1);
      compare <= wr_compare ? wr_data : compare;
      armed <= armed | wr_compare;
      ti <= ~wr_compare & ((armed & count == compare) | (ti & ~(wr_cause & wr_data[TI_BIT])));
      ie <= wr_status ? wr_data[IE_BIT] : ie;
      im <= wr_status ? wr_data[IM_LSB +: 8] : im;
      exl <= take_exc | (~eret & (wr_status ? wr_data[EXL_BIT] : exl));
      code <= take_exc ? (exc_req ? exc_code : EXC_INT) : code;
      epc_q <= take_exc & ~exl ? pc : wr_epc ? wr_data : epc_q;
    end
  end
endmodule

// File: tb/tb_cp0_intc.sv
// tb_cp0_intc: directed stimulus with a queued scoreboard for cp0_intc
module tb_cp0_intc;
  logic clk = 1'b0;
  logic reset, instr_done, exc_req, eret, mtc0_en, take_exc, int_pending;
  logic [31:0] pc, wr_data, rd_data, vector, epc, status, cause;
  logic [3:0] irq_in;
  logic [4:0] exc_code, addr;
  typedef struct {
    int cyc;
    int sel;
    logic [31:0] exp;
    string name;
  } exp_t;
  exp_t q[$];
  int cyc = 0;
  int checks = 0;
  int failures = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  cp0_intc dut (
    .clk(clk),
    .reset(reset),
    .pc(pc),
    .instr_done(instr_done),
    .irq_in(irq_in),
    .exc_req(exc_req),
    .exc_code(exc_code),
    .eret(eret),
    .mtc0_en(mtc0_en),
    .addr(addr),
    .wr_data(wr_data),
    .rd_data(rd_data),
    .take_exc(take_exc),
    .vector(vector),
    .epc(epc),
    .status(status),
    .cause(cause),
    .int_pending(int_pending)
  );
  function automatic logic [31:0] get(int sel);
    return sel == 0 ? rd_data :
           sel == 1 ? {31'b0, take_exc} :
           sel == 2 ? epc :
           sel == 3 ? status :
           sel == 4 ? cause :
           sel == 5 ? {31'b0, int_pending} : vector;
  endfunction
  always @(negedge clk) begin
    exp_t e;
    logic [31:0] act;
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      e = q.pop_front();
      act = get(e.sel);
      checks++;
      if (act !== e.exp) begin
        failures++;
        $display("FAIL %s cyc=%0d got=%h want=%h", e.name, e.cyc, act, e.exp);
      end
    end
  end
  task automatic next();
    @(posedge clk);
    #1;
    instr_done = 1'b0;
    exc_req = 1'b0;
    eret = 1'b0;
    mtc0_en = 1'b0;
  endtask
  task automatic chk(int sel, logic [31:0] v, string n);
    exp_t e;
    e.cyc = cyc;
    e.sel = sel;
    e.exp = v;
    e.name = n;
    q.push_back(e);
  endtask
  task automatic wr(logic [4:0] a, logic [31:0] d);
    mtc0_en = 1'b1;
    addr = a;
    wr_data = d;
  endtask
  initial begin
    reset = 1'b1;
    irq_in = '0;
    pc = '0;
    wr_data = '0;
    addr = '0;
    exc_code = '0;
    instr_done = 1'b0;
    exc_req = 1'b0;
    eret = 1'b0;
    mtc0_en = 1'b0;
    next();
    exc_req = 1'b1;
    chk(1, 0, "take_in_reset");
    next();
    reset = 1'b0;
    addr = 12;
    chk(0, 0, "rd_status_rst");
    chk(5, 0, "intp_rst");
    chk(6, 32'h80000180, "vector");
    next();
    addr = 13;
    chk(0, 0, "rd_cause_rst");
    next();
    addr = 14;
    chk(0, 0, "rd_epc_rst");
    irq_in = 4'b0001;
    instr_done = 1'b1;
    chk(1, 0, "take_ie0_a");
    next();
    irq_in = '0;
    instr_done = 1'b1;
    chk(1, 0, "take_ie0_b");
    chk(4, 32'h100, "ip8_set_ie0");
    wr(13, 32'h100);
    next();
    chk(4, 0, "ip8_w1c");
    wr(12, 32'h101);
    next();
    addr = 12;
    chk(0, 32'h101, "rd_status_wr");
    irq_in = 4'b0001;
    chk(1, 0, "take_edge_cycle");
    chk(5, 0, "intp_edge_cycle");
    next();
    chk(5, 1, "intp_after_edge");
    chk(1, 0, "take_no_done");
    next();
    instr_done = 1'b1;
    pc = 32'h40;
    chk(1, 1, "take_irq");
    next();
    chk(2, 32'h40, "epc_irq");
    chk(3, 32'h103, "status_exl");
    chk(4, 32'h100, "cause_int");
    chk(5, 0, "intp_exl");
    eret = 1'b1;
    chk(1, 0, "take_eret");
    next();
    chk(3, 32'h101, "status_eret");
    chk(2, 32'h40, "epc_eret");
    chk(5, 1, "intp_eret");
    exc_req = 1'b1;
    exc_code = 5'd12;
    instr_done = 1'b1;
    pc = 32'h80;
    chk(1, 1, "take_exc_prio");
    next();
    chk(4, 32'h130, "cause_ov");
    chk(2, 32'h80, "epc_ov");
    chk(3, 32'h103, "status_ov");
    exc_req = 1'b1;
    exc_code = 5'd8;
    pc = 32'hC0;
    chk(1, 1, "take_nested");
    next();
    chk(2, 32'h80, "epc_nested");
    chk(4, 32'h120, "cause_sys");
    chk(3, 32'h103, "status_nested");
    eret = 1'b1;
    exc_req = 1'b1;
    exc_code = 5'd10;
    pc = 32'h100;
    chk(1, 1, "take_with_eret");
    next();
    chk(3, 32'h103, "status_eret_drop");
    chk(2, 32'h80, "epc_eret_drop");
    chk(4, 32'h128, "cause_ri");
    eret = 1'b1;
    next();
    chk(3, 32'h101, "status_eret2");
    chk(2, 32'h80, "epc_eret2");
    wr(13, 32'h100);
    irq_in = '0;
    next();
    chk(4, 32'h28, "cause_clr_ip8");
    chk(5, 0, "intp_clr");
    wr(12, 32'h8001);
    next();
    wr(9, 32'd10);
    next();
    wr(11, 32'd20);
    next();
    addr = 9;
    chk(0, 32'd11, "rd_count");
    for (int i = 0; i < 9; i++) next();
    addr = 9;
    chk(0, 32'd20, "count_eq_cmp");
    chk(4, 32'h28, "ti_not_yet");
    next();
    chk(4, 32'h8028, "ti_set");
    chk(5, 1, "intp_timer");
    wr(11, 32'd100);
    next();
    chk(4, 32'h28, "ti_clr_cmp");
    chk(5, 0, "intp_timer_clr");
    irq_in = 4'b0001;
    wr(13, 32'h100);
    next();
    chk(4, 32'h128, "set_wins_w1c");
    chk(5, 0, "intp_im0_off");
    wr(13, 32'h100);
    next();
    chk(4, 32'h28, "w1c_no_edge");
    exc_req = 1'b1;
    exc_code = 5'd8;
    pc = 32'h200;
    wr(12, 32'hFF00);
    chk(1, 1, "take_with_mtc0");
    next();
    chk(3, 32'hFF02, "status_mtc0_take");
    chk(2, 32'h200, "epc_mtc0_take");
    chk(4, 32'h20, "cause_mtc0_take");
    chk(5, 0, "intp_mtc0_take");
    reset = 1'b1;
    exc_req = 1'b1;
    chk(1, 0, "take_mid_reset");
    next();
    reset = 1'b0;
    addr = 14;
    chk(3, 0, "status_rst2");
    chk(4, 0, "cause_rst2");
    chk(2, 0, "epc_rst2");
    chk(5, 0, "intp_rst2");
    chk(0, 0, "rd_epc_rst2");
    next();
    next();
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain left=%0d want=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
